universal_shift_register: RTL
=============================

// Module: universal_shift_register
// PURPOSE
//  Parametrised successor to the single-bit serial-in/serial-out register.
//  Supports four modes: hold, shift right, shift left and parallel load.
//  Has serial taps at both ends and a shift counter that raises a 1-cycle
//  word_done strobe and captures word_q after every WIDTH shifts.
//  Serves as the generic SISO/SIPO/PISO/PIPO element for serial links.
// PARAMETERS
//  WIDTH        8     register length in bits; WIDTH >= 2
//  RESET_VALUE  0     value loaded into q on reset (WIDTH bits)
//  CNT_W        $clog2(WIDTH)   counter width; derived, not overridden
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  en          in   1        operation enable; 0 = hold everything
//  mode        in   2        00 hold, 01 shift right, 10 shift left, 11 load
//  sr_in       in   1        serial input into MSB on shift right
//  sl_in       in   1        serial input into LSB on shift left
//  pin         in   WIDTH    parallel load data
//  q           out  WIDTH    register contents
//  so_lsb      out  1        q[0], serial output for shift right
//  so_msb      out  1        q[WIDTH-1], serial output for shift left
//  shift_cnt   out  CNT_W    shifts completed in the current word
//  word_done   out  1        1-cycle strobe: WIDTH shifts just completed
//  word_q      out  WIDTH    snapshot of q at the last word completion
// BEHAVIOUR
//  - Reset (rst=1 at posedge): q<=RESET_VALUE, shift_cnt<=0, word_done<=0,
//    word_q<=0. Reset overrides en and mode and aborts a partial word.
//  - en=0: q, shift_cnt and word_q hold; word_done<=0.
//  - en=1, mode 00: q and shift_cnt hold; word_done<=0.
//  - en=1, mode 01: q <= {sr_in, q[WIDTH-1:1]}.
//  - en=1, mode 10: q <= {q[WIDTH-2:0], sl_in}.
//  - en=1, mode 11: q <= pin; shift_cnt<=0; word_done<=0. The load aborts
//    any partial word. Latency is 1 cycle.
//  - On any shift (01/10): if shift_cnt==WIDTH-1, then shift_cnt<=0,
//    word_done<=1 and word_q<=post-shift q (the same value q takes this
//    edge). Otherwise shift_cnt<=shift_cnt+1 and word_done<=0.
//  - Mixed-direction shifts count toward the same word, with no error.
//  - word_done is high for exactly one cycle. Back-to-back words give a
//    strobe every WIDTH cycles, and shift_cnt wraps with no gap cycle.
//  - so_lsb and so_msb are combinational taps of q, i.e. the registered
//    value, not a look-ahead.
//  - All outputs are registered or direct taps of registers. There is no
//    combinational input-to-output path.
// STRUCTURE
//  - shift_modes.vh (shared include): MODE_HOLD=2'b00, MODE_SHR=2'b01,
//    MODE_SHL=2'b10, MODE_LOAD=2'b11. Serial-link blocks reuse these.
//  - Sub-module shift_bit_counter #(WIDTH): inputs clk, rst, inc, clr;
//    outputs cnt and wrap. It owns shift_cnt and the wrap detection.
//  - Top level contains the data register, mode mux and word_q/word_done
//    registers.
// TESTING  (WIDTH=8, RESET_VALUE=0 unless stated)
//  1. Hold rst=1 for 2 cycles with en=1, mode=11, pin=FF.
//     -> q=00, shift_cnt=0, word_done=0, word_q=00.
//  2. en=1, mode=11, pin=A5 for 1 cycle, then mode=00.
//     -> q=A5 after 1 edge, so_msb=1, so_lsb=1, shift_cnt=0, q holds A5.
//  3. Shift right 8 times, sr_in = bits 0..7 of 32'hC6EF15AD, LSB first.
//     -> q=AD, word_done=1 for exactly 1 cycle, word_q=AD, shift_cnt=0.
//     Continue with bits 8..15 -> second strobe 8 cycles later, word_q=15.
//  4. From q=00, shift left 3 times with sl_in=1.
//     -> q=07, shift_cnt=3, so_msb=0, so_lsb=1, no word_done.
//  5. At shift_cnt=7, apply mode=11 with pin=3C.
//     -> q=3C, shift_cnt=0, no word_done, word_q keeps its prior value.
//  6. After 5 right shifts, en=0 for 4 cycles -> all registers hold.
//     Then rst=1 for 1 cycle -> q=00, shift_cnt=0, word_done stays 0.

Source files
------------

// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register and the serial-link
// blocks built on it: mode encoding and small mode-decoding helpers.
package universal_shift_register_pkg;

  // Operating modes. These encodings are what sits on the 2-bit mode bus.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_e;

  // True for the two modes that move one bit and advance the word counter.
  function automatic logic is_shift(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

  // True for the mode that replaces the register and aborts a partial word.
  function automatic logic is_load(input logic [1:0] mode);
    return mode == MODE_LOAD;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Counts shifts within the current word. wrap is asserted on the increment
// that completes a word (cnt at WIDTH-1), in the same cycle, so the parent
// can register its strobe and snapshot on that edge. The counter returns to
// zero on the wrapping edge with no idle cycle in between.
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Word completion: this increment is the WIDTH-th shift of the word.
  assign wrap = inc && !clr && (cnt == LAST);

  // Shift counter: reset and clear abort the word, wrap restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with serial taps at both ends, a per-word shift counter, a one-cycle
// word_done strobe and a word_q snapshot taken on every completed word.
// Every output is a register or a direct tap of one.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             so_lsb,
  output logic             so_msb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done,
  output logic [WIDTH-1:0] word_q
);

  logic [WIDTH-1:0] q_next;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             cnt_wrap;

  // Counter controls: only enabled shifts count, an enabled load aborts.
  assign cnt_inc = en && is_shift(mode);
  assign cnt_clr = en && is_load(mode);

  // Mode mux: the value q takes on the next edge (also the word snapshot).
  always_comb begin
    q_next = q;
    if (en) begin
      case (mode)
        MODE_SHR:  q_next = {sr_in, q[WIDTH-1:1]};
        MODE_SHL:  q_next = {q[WIDTH-2:0], sl_in};
        MODE_LOAD: q_next = pin;
        default:   q_next = q;
      endcase
    end
  end

  // Data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= q_next;
    end
  end

  // Word completion: strobe for one cycle and capture the post-shift value.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_done <= 1'b0;
      word_q    <= '0;
    end else begin
      word_done <= cnt_wrap;
      if (cnt_wrap) begin
        word_q <= q_next;
      end
    end
  end

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .cnt  (shift_cnt),
    .wrap (cnt_wrap)
  );

  // Serial taps are the registered end bits, not a look-ahead.
  assign so_lsb = q[0];
  assign so_msb = q[WIDTH-1];

endmodule
